// File: rtl/l2_backing_memory.sv
// l2_backing_memory
// Block-granular main-memory responder below the L2 cache.
// Block reads are answered after READ_LATENCY cycles with a one-cycle o_mem_ready pulse.
// Single-cycle writes commit a whole block at any time, independent of the read FSM.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no read in flight; a sampled i_mem_read is accepted
// S_BUSY | read accepted, latency down-counter running toward zero
// S_HOLD | response issued; waiting for the requester to drop i_mem_read
//
// READ_LATENCY must be >= 1.

module l2_backing_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int BLOCK_SIZE   = 32,
  parameter int READ_LATENCY = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [ADDR_WIDTH-1:0]            i_mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] i_mem_data_out,
  input  logic                             i_mem_read,
  input  logic                             i_mem_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] o_mem_data_block,
  output logic                             o_mem_ready
);

  localparam int OFF_W      = $clog2(BLOCK_SIZE);
  localparam int BLK_W      = ADDR_WIDTH - OFF_W;
  localparam int NUM_BLOCKS = 2 ** BLK_W;
  localparam int BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;
  localparam int CNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BLK_W-1:0]      r_rd_blk;
  logic [BLOCK_BITS-1:0] r_mem [NUM_BLOCKS];

  logic [BLK_W-1:0]      w_blk;
  logic                  w_fwd_busy;
  logic [BLOCK_BITS-1:0] w_rsp_busy;
  logic [BLOCK_BITS-1:0] w_rsp_idle;
  logic                  w_unused_off;

  assign w_blk        = i_mem_addr[ADDR_WIDTH-1:OFF_W];
  assign w_unused_off = ^i_mem_addr[OFF_W-1:0];

  // Response data with write forwarding: a write landing on the same edge as
  // the response must be returned, since the array only updates after that edge.
  assign w_fwd_busy = i_mem_write && (w_blk == r_rd_blk);
  assign w_rsp_busy = w_fwd_busy ? i_mem_data_out : r_mem[r_rd_blk];
  // Zero-wait response (READ_LATENCY==1): read and write share i_mem_addr, so any write hits.
  assign w_rsp_idle = i_mem_write ? i_mem_data_out : r_mem[w_blk];

  // Storage array: whole-block writes in every FSM state, cleared on reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_mem_write) begin
      r_mem[w_blk] <= i_mem_data_out;
    end
  end

  // Read FSM: accept, count down the latency, pulse ready, then wait for the request to drop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_rd_blk         <= '0;
      o_mem_ready      <= 1'b0;
      o_mem_data_block <= '0;
    end else begin
      o_mem_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_mem_read) begin
            r_rd_blk <= w_blk;
            if (READ_LATENCY == 1) begin
              o_mem_data_block <= w_rsp_idle;
              o_mem_ready      <= 1'b1;
              r_cnt            <= '0;
              r_state          <= S_HOLD;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            o_mem_data_block <= w_rsp_busy;
            o_mem_ready      <= 1'b1;
            r_state          <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_HOLD: begin
          if (!i_mem_read) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_backing_memory.sv
// Testbench for l2_backing_memory: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-level behavioural model of the memory.

module tb_l2_backing_memory;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int BS    = 32;
  localparam int RL    = 4;
  localparam int OFF_W = 5;
  localparam int NB    = 64;
  localparam int BW    = DW * BS;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [BW-1:0] wdata = '0;
  logic [BW-1:0] rdata;
  logic          rdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_backing_memory #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BLOCK_SIZE  (BS),
    .READ_LATENCY(RL)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mem_addr      (addr),
    .i_mem_data_out  (wdata),
    .i_mem_read      (rd),
    .i_mem_write     (wr),
    .o_mem_data_block(rdata),
    .o_mem_ready     (rdy)
  );

  // Compare and report the first differing word on mismatch.
  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int w;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int i = BS - 1; i >= 0; i--) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
      end
      $display("FAIL %s: word %0d got %h expected %h", tag, w, act[w*DW +: DW], exp[w*DW +: DW]);
    end
  endtask

  function automatic logic [BW-1:0] fill(input logic [DW-1:0] v);
    return {BS{v}};
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < BS; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] blk_addr(input int b, input int off);
    logic [AW-1:0] a;
    a = AW'((b << OFF_W) | (off & (BS - 1)));
    return a;
  endfunction

  // Reference model: memory contents, and whether a read is in flight or awaiting release.
  logic [BW-1:0] m_mem [NB];
  logic [BW-1:0] m_out;
  logic          m_rdy;
  bit            m_inflight, m_waitlow;
  int            m_due, m_blk, cyc;

  always @(posedge clk) begin : model
    bit idle;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) m_mem[i] = '0;
      m_out      = '0;
      m_rdy      = 1'b0;
      m_inflight = 0;
      m_waitlow  = 0;
    end else begin
      idle  = !m_inflight && !m_waitlow;
      m_rdy = 1'b0;
      if (wr) m_mem[int'(addr) / BS] = wdata;
      if (m_waitlow) begin
        if (!rd) m_waitlow = 0;
      end else if (m_inflight) begin
        if (cyc == m_due) begin
          m_rdy      = 1'b1;
          m_out      = m_mem[m_blk];
          m_inflight = 0;
          m_waitlow  = 1;
        end
      end else if (idle && rd) begin
        m_blk = int'(addr) / BS;
        if (RL == 1) begin
          m_rdy     = 1'b1;
          m_out     = m_mem[m_blk];
          m_waitlow = 1;
        end else begin
          m_inflight = 1;
          m_due      = cyc + RL;
        end
      end
    end
    #1;
    check("ready", BW'(rdy), BW'(m_rdy));
    check("block", rdata, m_out);
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Requester: raise read, wait (bounded) for ready, keep read high for 'extra' cycles, drop.
  task automatic do_read(input logic [AW-1:0] a, input int extra,
                         output logic [BW-1:0] got, output int lat);
    bit ok;
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    ok   = 0;
    lat  = -1;
    got  = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rdy) begin
        ok  = 1;
        got = rdata;
        lat = i;
      end
    end
    check("read_timeout", BW'(ok), BW'(1));
    repeat (extra) @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] got, pat;
    int            lat, pulses;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then read of a never-written block.
    check("rst_block", rdata, '0);
    check("rst_ready", BW'(rdy), '0);
    do_read(11'h040, 0, got, lat);
    check("t1_latency", BW'(lat), BW'(RL));
    check("t1_data", got, '0);
    @(negedge clk);
    check("t1_single_pulse", BW'(rdy), '0);

    // Write with per-word pattern; read back through a non-zero offset.
    for (int i = 0; i < BS; i++) pat[i*DW +: DW] = 32'hA500_0000 + DW'(i);
    do_write(blk_addr(5, 0), pat);
    do_read(11'h0A3, 0, got, lat);
    check("t2_word31", BW'(got[31*DW +: DW]), BW'(32'hA500_001F));
    check("t2_block", got, pat);

    // Requester lag: read held two cycles past ready, then an immediate new read.
    pulses = 0;
    fork
      do_read(blk_addr(5, 7), 2, got, lat);
      for (int i = 0; i < RL + 4; i++) begin
        @(negedge clk);
        if (rdy) pulses++;
      end
    join
    check("t3_one_pulse", BW'(pulses), BW'(1));
    do_read(blk_addr(2, 0), 0, got, lat);
    check("t3_next_latency", BW'(lat), BW'(RL));

    // Write to the in-flight block on the response edge is forwarded.
    @(negedge clk);
    addr = blk_addr(7, 0);
    rd   = 1'b1;
    repeat (RL) @(negedge clk);
    wdata = fill(32'h1234_5678);
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    check("t4_ready", BW'(rdy), BW'(1));
    check("t4_forward", rdata, fill(32'h1234_5678));
    rd = 1'b0;

    // Simultaneous read and write in IDLE returns the written block.
    @(negedge clk);
    addr  = blk_addr(3, 4);
    wdata = fill(32'hDEAD_BEEF);
    wr    = 1'b1;
    rd    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    do_read(blk_addr(3, 0), 0, got, lat);
    check("t5_rw_same_cycle", got, fill(32'hDEAD_BEEF));

    // Reset during BUSY aborts the read and clears the array.
    for (int b = 0; b < NB; b += 9) do_write(blk_addr(b, 0), rand_blk());
    @(negedge clk);
    addr = blk_addr(9, 0);
    rd   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    rd    = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < RL + 4; i++) begin
      @(negedge clk);
      if (rdy) pulses++;
    end
    check("t6_no_ready", BW'(pulses), '0);
    check("t6_block_zero", rdata, '0);
    for (int b = 0; b < NB; b++) begin
      do_read(blk_addr(b, b), 0, got, lat);
      check("t6_cleared", got, '0);
    end

    // Randomized traffic: arbitrary read/write/address patterns, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rd    = ($urandom_range(0, 2) != 0);
      wr    = ($urandom_range(0, 3) == 0);
      addr  = AW'($urandom);
      wdata = rand_blk();
      if (i % 8 == 0) addr = blk_addr($urandom_range(0, 3), $urandom_range(0, 31));
    end
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    repeat (RL + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
